dvi_timing_ctrl: RTL

Video timing sequencer that drives the `DVI_out` block in the `pixclk` domain. It generates the raster counters, `vde`, `hSync` and `vSync`, and the pixel coordinates. It also schedules one line-fetch request per active line to the framebuffer/scan-line buffer through a req/ack handshake, so pixel data is ready before each active line starts.

---
 rtl/dvi_timing_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/dvi_timing_ctrl.sv
// dvi_timing_ctrl: raster timing sequencer for DVI_out (pixclk domain).
// Generates x/y counters, vde, hSync, vSync and frame_start. It also issues one
// line-fetch request per active line through a req/ack handshake, so the line is
// fetched before it is displayed. All outputs are registered and mutually aligned.
// Optional macro DVI_LINE_DOUBLE_EN: only even target lines are fetched, and
// line_num = target >> 1 (2x vertical line doubling).
// Ports: pixclk, reset (sync, active-high), enable, line_ack (in);
//        vde, hSync, vSync, x, y, frame_start, line_req, line_num, underrun (out).
module dvi_timing_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic        pixclk,
    input  logic        reset,
    input  logic        enable,
    output logic        vde,
    output logic        hSync,
    output logic        vSync,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        frame_start,
    output logic        line_req,
    output logic [11:0] line_num,
    input  logic        line_ack,
    output logic        underrun
);

    localparam int unsigned CW      = 12;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t          state, state_nx;
    logic            running;          // outputs currently show a live raster position
    logic [CW-1:0]   nx, ny;           // position the outputs will show after this edge
    logic [CW-1:0]   ty;               // line following ny
    logic [CW-1:0]   tgt, tgt_nx;      // line the pending request is for
    logic [CW-1:0]   lnum, lnum_nx;
    logic            want;
    logic            urun_nx;
    logic            vde_nx, hs_on, vs_on, fs_nx;

    // Next raster position; the first live edge shows (0,0) rather than advancing.
    always_comb begin
        nx = '0;
        ny = '0;
        if (enable && running) begin
            if (x == CW'(H_TOTAL - 1)) begin
                nx = '0;
                ny = (y == CW'(V_TOTAL - 1)) ? '0 : y + CW'(1);
            end else begin
                nx = x + CW'(1);
                ny = y;
            end
        end
        ty = (ny == CW'(V_TOTAL - 1)) ? '0 : ny + CW'(1);
    end

    // Target-line qualification and line_num mapping.
    always_comb begin
`ifdef DVI_LINE_DOUBLE_EN
        want = (ty < CW'(V_ACTIVE)) && !ty[0];
        lnum = ty >> 1;
`else
        want = (ty < CW'(V_ACTIVE));
        lnum = ty;
`endif
    end

    // Fetch FSM next state; underrun is checked before a new request can start.
    always_comb begin
        state_nx = state;
        tgt_nx   = tgt;
        lnum_nx  = line_num;
        urun_nx  = 1'b0;
        if (!enable) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (nx == CW'(H_ACTIVE) && want) begin
                        state_nx = S_REQ;
                        tgt_nx   = ty;
                        lnum_nx  = lnum;
                    end
                end
                S_REQ: begin
                    if (line_ack) begin
                        state_nx = S_IDLE;
                    end else if (nx == '0 && ny == tgt) begin
                        state_nx = S_IDLE;
                        urun_nx  = 1'b1;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Raster decode of the next position.
    always_comb begin
        vde_nx = enable && (nx < CW'(H_ACTIVE)) && (ny < CW'(V_ACTIVE));
        hs_on  = enable && (nx >= CW'(H_ACTIVE + H_FP)) && (nx < CW'(H_ACTIVE + H_FP + H_SYNC));
        vs_on  = enable && (ny >= CW'(V_ACTIVE + V_FP)) && (ny < CW'(V_ACTIVE + V_FP + V_SYNC));
        fs_nx  = enable && (nx == '0) && (ny == '0);
    end

    always_ff @(posedge pixclk) begin
        if (reset) begin
            state       <= S_IDLE;
            running     <= 1'b0;
            x           <= '0;
            y           <= '0;
            vde         <= 1'b0;
            hSync       <= ~HS_POL;
            vSync       <= ~VS_POL;
            frame_start <= 1'b0;
            line_req    <= 1'b0;
            line_num    <= '0;
            tgt         <= '0;
            underrun    <= 1'b0;
        end else begin
            state       <= state_nx;
            running     <= enable;
            x           <= nx;
            y           <= ny;
            vde         <= vde_nx;
            hSync       <= hs_on ? HS_POL : ~HS_POL;
            vSync       <= vs_on ? VS_POL : ~VS_POL;
            frame_start <= fs_nx;
            line_req    <= (state_nx == S_REQ);
            line_num    <= lnum_nx;
            tgt         <= tgt_nx;
            underrun    <= urun_nx;
        end
    end

endmodule
